tft_timing_gen: RTL and testbench

Parametrised TFT panel timing generator, the next generation of the single-resolution tft driver counter.
- Generates full horizontal/vertical timing (front porch, sync, back porch), data enable, sync strobes and fetch coordinates for any panel geometry.
- Sequences panel power up/down and stops cleanly on a frame boundary.
- Registers and widens renderer colour with the pipeline latency matched to DE/sync.
- Sits between the pixel renderer (which consumes x/y) and the TFT pins.

---
 rtl/tft_pkg.sv | 35 +++
 rtl/tft_axis_counter.sv | 41 ++++
 rtl/tft_timing_gen.sv | 154 +++++++++++++++
 tb/tb_tft_timing_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT timing generator: FSM encoding, default
// panel timing and the renderer-to-panel colour widening helper.
package tft_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_PWR_UP,
      ST_RUN,
      ST_DRAIN,
      ST_PWR_DOWN
   } tft_state_t;

   localparam int DEF_H_ACTIVE  = 480;
   localparam int DEF_H_FP      = 2;
   localparam int DEF_H_SYNC    = 41;
   localparam int DEF_H_BP      = 2;
   localparam int DEF_V_ACTIVE  = 272;
   localparam int DEF_V_FP      = 2;
   localparam int DEF_V_SYNC    = 10;
   localparam int DEF_V_BP      = 4;
   localparam int DEF_X_BITS    = 10;
   localparam int DEF_Y_BITS    = 9;
   localparam int DEF_BPC_IN    = 3;
   localparam int DEF_BPC_OUT   = 8;
   localparam int DEF_PWR_DELAY = 16;

   // Left-justifies a bpc_in wide value in a bpc_out wide field, low bits zero.
   // Supports panel depths up to 16 bits per colour.
   function automatic logic [15:0] expand_bpc(input logic [15:0] v,
                                              input int bpc_in,
                                              input int bpc_out);
      return v << (bpc_out - bpc_in);
   endfunction

endpackage

// File: rtl/tft_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping position counter plus
// active / sync region decode in the order active, FP, SYNC, BP.
module tft_axis_counter #(
   parameter int ACTIVE = 480,
   parameter int FP     = 2,
   parameter int SYNC   = 41,
   parameter int BP     = 2,
   parameter int BITS   = 10
) (
   input  logic            tft_clk,
   input  logic            rstb,
   input  logic            advance,
   input  logic            clear,
   output logic [BITS-1:0] count,
   output logic            wrap,
   output logic            in_active,
   output logic            in_sync
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   // Inclusive bounds keep every constant below TOTAL, so none can overflow BITS.
   localparam logic [BITS-1:0] LAST       = BITS'(TOTAL - 1);
   localparam logic [BITS-1:0] ACT_LAST   = BITS'(ACTIVE - 1);
   localparam logic [BITS-1:0] SYNC_FIRST = BITS'(ACTIVE + FP);
   localparam logic [BITS-1:0] SYNC_LAST  = BITS'(ACTIVE + FP + SYNC - 1);

   assign wrap      = (count == LAST);
   assign in_active = (count <= ACT_LAST);
   assign in_sync   = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

   always_ff @(posedge tft_clk or negedge rstb) begin
      if (!rstb)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (advance)
         count <= wrap ? '0 : count + BITS'(1);
   end

endmodule

// File: rtl/tft_timing_gen.sv
// TFT panel timing generator: power sequencing FSM, H/V counters, fetch
// coordinates and a one-stage output register aligning colour, DE and syncs.
module tft_timing_gen
   import tft_pkg::*;
#(
   parameter int H_ACTIVE     = DEF_H_ACTIVE,
   parameter int H_FP         = DEF_H_FP,
   parameter int H_SYNC       = DEF_H_SYNC,
   parameter int H_BP         = DEF_H_BP,
   parameter int V_ACTIVE     = DEF_V_ACTIVE,
   parameter int V_FP         = DEF_V_FP,
   parameter int V_SYNC       = DEF_V_SYNC,
   parameter int V_BP         = DEF_V_BP,
   parameter int X_BITS       = DEF_X_BITS,
   parameter int Y_BITS       = DEF_Y_BITS,
   parameter int BPC_IN       = DEF_BPC_IN,
   parameter int BPC_OUT      = DEF_BPC_OUT,
   parameter int PWR_DELAY    = DEF_PWR_DELAY,
   parameter int SYNC_ACT_LOW = 1
) (
   input  logic               tft_clk,
   input  logic               rstb,
   input  logic               enable,
   input  logic [BPC_IN-1:0]  pix_r,
   input  logic [BPC_IN-1:0]  pix_g,
   input  logic [BPC_IN-1:0]  pix_b,
   output logic [X_BITS-1:0]  x,
   output logic [Y_BITS-1:0]  y,
   output logic               fetch_valid,
   output logic               new_frame,
   output logic [15:0]        frame_count,
   output logic [BPC_OUT-1:0] tft_red,
   output logic [BPC_OUT-1:0] tft_green,
   output logic [BPC_OUT-1:0] tft_blue,
   output logic               tft_data_ena,
   output logic               tft_hsync,
   output logic               tft_vsync,
   output logic               tft_vdd,
   output logic               tft_display,
   output logic               running
);

   localparam int              PW_BITS  = $clog2(PWR_DELAY + 1);
   localparam logic [PW_BITS-1:0] PW_LAST = PW_BITS'(PWR_DELAY - 1);
   localparam logic            SYNC_OFF = (SYNC_ACT_LOW != 0);

   tft_state_t         state, state_nxt;
   logic [PW_BITS-1:0] pwr_cnt;
   logic               pwr_phase, pwr_done;
   logic               counting;
   logic [X_BITS-1:0]  hcnt;
   logic [Y_BITS-1:0]  vcnt;
   logic               h_wrap, h_active, h_sync;
   logic               v_wrap, v_active, v_sync;
   logic               de_nxt;

   assign counting  = (state == ST_RUN) || (state == ST_DRAIN);
   assign pwr_phase = (state == ST_PWR_UP) || (state == ST_PWR_DOWN);
   assign pwr_done  = (pwr_cnt == PW_LAST);

   tft_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .BITS   (X_BITS)
   ) u_hcnt (
      .tft_clk   (tft_clk),
      .rstb      (rstb),
      .advance   (counting),
      .clear     (!counting),
      .count     (hcnt),
      .wrap      (h_wrap),
      .in_active (h_active),
      .in_sync   (h_sync)
   );

   tft_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .BITS   (Y_BITS)
   ) u_vcnt (
      .tft_clk   (tft_clk),
      .rstb      (rstb),
      .advance   (counting && h_wrap),
      .clear     (!counting),
      .count     (vcnt),
      .wrap      (v_wrap),
      .in_active (v_active),
      .in_sync   (v_sync)
   );

   assign x           = hcnt;
   assign y           = vcnt;
   assign fetch_valid = h_active && v_active && (state == ST_RUN);
   assign new_frame   = counting && h_wrap && v_wrap;
   assign running     = counting;
   assign de_nxt      = h_active && v_active && counting;

   // Power delays ignore enable; a returning enable in DRAIN wins over the frame end.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_OFF:      if (enable)   state_nxt = ST_PWR_UP;
         ST_PWR_UP:   if (pwr_done) state_nxt = ST_RUN;
         ST_RUN:      if (!enable)  state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)         state_nxt = ST_RUN;
            else if (new_frame) state_nxt = ST_PWR_DOWN;
         end
         ST_PWR_DOWN: if (pwr_done) state_nxt = ST_OFF;
         default:                   state_nxt = ST_OFF;
      endcase
   end

   always_ff @(posedge tft_clk or negedge rstb) begin
      if (!rstb) begin
         state       <= ST_OFF;
         pwr_cnt     <= '0;
         tft_vdd     <= 1'b0;
         tft_display <= 1'b0;
         frame_count <= '0;
      end else begin
         state       <= state_nxt;
         pwr_cnt     <= (pwr_phase && !pwr_done) ? pwr_cnt + PW_BITS'(1) : '0;
         tft_vdd     <= (state_nxt != ST_OFF);
         tft_display <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
         if (new_frame)
            frame_count <= frame_count + 16'd1;
      end
   end

   // Pin stage: everything the panel sees is registered together from cycle N.
   always_ff @(posedge tft_clk or negedge rstb) begin
      if (!rstb) begin
         tft_data_ena <= 1'b0;
         tft_red      <= '0;
         tft_green    <= '0;
         tft_blue     <= '0;
         tft_hsync    <= SYNC_OFF;
         tft_vsync    <= SYNC_OFF;
      end else begin
         tft_data_ena <= de_nxt;
         tft_red      <= de_nxt ? BPC_OUT'(expand_bpc(16'(pix_r), BPC_IN, BPC_OUT)) : '0;
         tft_green    <= de_nxt ? BPC_OUT'(expand_bpc(16'(pix_g), BPC_IN, BPC_OUT)) : '0;
         tft_blue     <= de_nxt ? BPC_OUT'(expand_bpc(16'(pix_b), BPC_IN, BPC_OUT)) : '0;
         tft_hsync    <= (counting && h_sync) ? ~SYNC_OFF : SYNC_OFF;
         tft_vsync    <= (counting && v_sync) ? ~SYNC_OFF : SYNC_OFF;
      end
   end

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench for tft_timing_gen on a small 17x9 geometry (active 10x5)
// so whole frames, drain and power sequencing fit in a short run.
module tb_tft_timing_gen;

   logic        tft_clk;
   logic        rstb;
   logic        enable;
   logic [2:0]  pix_r, pix_g, pix_b;
   logic [4:0]  x;
   logic [3:0]  y;
   logic        fetch_valid, new_frame;
   logic [15:0] frame_count;
   logic [7:0]  tft_red, tft_green, tft_blue;
   logic        tft_data_ena, tft_hsync, tft_vsync, tft_vdd, tft_display, running;

   int checks = 0;
   int errors = 0;
   int de_cnt, hs_low, vs_low;

   tft_timing_gen #(
      .H_ACTIVE (10), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_ACTIVE (5),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .X_BITS (5), .Y_BITS (4), .BPC_IN (3), .BPC_OUT (8),
      .PWR_DELAY (16), .SYNC_ACT_LOW (1)
   ) dut (
      .tft_clk      (tft_clk),
      .rstb         (rstb),
      .enable       (enable),
      .pix_r        (pix_r),
      .pix_g        (pix_g),
      .pix_b        (pix_b),
      .x            (x),
      .y            (y),
      .fetch_valid  (fetch_valid),
      .new_frame    (new_frame),
      .frame_count  (frame_count),
      .tft_red      (tft_red),
      .tft_green    (tft_green),
      .tft_blue     (tft_blue),
      .tft_data_ena (tft_data_ena),
      .tft_hsync    (tft_hsync),
      .tft_vsync    (tft_vsync),
      .tft_vdd      (tft_vdd),
      .tft_display  (tft_display),
      .running      (running)
   );

   initial tft_clk = 1'b0;
   always #5 tft_clk = ~tft_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge tft_clk);
   endtask

   initial begin
      rstb = 1'b1; enable = 1'b0; pix_r = '0; pix_g = '0; pix_b = '0;
      #1 rstb = 1'b0;
      #2;
      chk("rst_vdd",     32'(tft_vdd), 0);
      chk("rst_display", 32'(tft_display), 0);
      chk("rst_hsync",   32'(tft_hsync), 1);
      chk("rst_vsync",   32'(tft_vsync), 1);
      chk("rst_de",      32'(tft_data_ena), 0);
      chk("rst_red",     32'(tft_red), 0);
      chk("rst_x",       32'(x), 0);
      chk("rst_y",       32'(y), 0);
      chk("rst_fc",      32'(frame_count), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_fv",      32'(fetch_valid), 0);

      @(negedge tft_clk); rstb = 1'b1;
      step(3);
      chk("off_vdd", 32'(tft_vdd), 0);
      chk("off_x",   32'(x), 0);

      // power up: vdd one clock after enable, display 16 clocks after vdd
      enable = 1'b1;
      step(1);
      chk("pu_vdd",      32'(tft_vdd), 1);
      chk("pu_display0", 32'(tft_display), 0);
      step(15);
      chk("pu_display15", 32'(tft_display), 0);
      step(1);
      chk("pu_display16", 32'(tft_display), 1);
      chk("run_running",  32'(running), 1);
      chk("run_x0",       32'(x), 0);
      chk("run_y0",       32'(y), 0);
      chk("run_fv",       32'(fetch_valid), 1);

      // colour widening with one clock latency
      step(5);
      chk("x5", 32'(x), 5);
      pix_r = 3'b011; pix_g = 3'b101; pix_b = 3'b111;
      step(1);
      chk("red_x5",   32'(tft_red), 32'h60);
      chk("green_x5", 32'(tft_green), 32'hA0);
      chk("blue_x5",  32'(tft_blue), 32'hE0);
      chk("de_x5",    32'(tft_data_ena), 1);
      step(4);
      chk("x10",    32'(x), 10);
      chk("fv_x10", 32'(fetch_valid), 0);
      step(1);
      chk("de_x10",  32'(tft_data_ena), 0);
      chk("red_x10", 32'(tft_red), 0);

      // hsync low for hcnt 12..14, seen one clock later
      step(1); chk("hs_11", 32'(tft_hsync), 1);
      step(1); chk("hs_12", 32'(tft_hsync), 0);
      step(2); chk("hs_14", 32'(tft_hsync), 0);
      step(1); chk("hs_15", 32'(tft_hsync), 1);
      step(1);
      chk("wrap_x", 32'(x), 0);
      chk("wrap_y", 32'(y), 1);

      // vsync low on lines 6 and 7
      step(85);
      chk("y6", 32'(y), 6);
      chk("vs_line5", 32'(tft_vsync), 1);
      step(1);  chk("vs_line6", 32'(tft_vsync), 0);
      step(33);
      chk("y8", 32'(y), 8);
      chk("vs_line7", 32'(tft_vsync), 0);
      step(1);  chk("vs_line8", 32'(tft_vsync), 1);

      // frame end at (16,8)
      step(15);
      chk("nf_x",  32'(x), 16);
      chk("nf",    32'(new_frame), 1);
      chk("nf_fc", 32'(frame_count), 0);
      step(1);
      chk("nf_off", 32'(new_frame), 0);
      chk("fc1",    32'(frame_count), 1);
      chk("f1_y",   32'(y), 0);

      // one full frame of pin activity
      de_cnt = 0; hs_low = 0; vs_low = 0;
      for (int i = 0; i < 153; i++) begin
         step(1);
         if (tft_data_ena) de_cnt++;
         if (!tft_hsync)   hs_low++;
         if (!tft_vsync)   vs_low++;
      end
      chk("de_cycles",  32'(de_cnt), 50);
      chk("hs_low_clk", 32'(hs_low), 27);
      chk("vs_low_clk", 32'(vs_low), 34);
      chk("fc2",        32'(frame_count), 2);

      // drain, re-enable, drain again to frame end, power down
      step(34);
      chk("drain_y", 32'(y), 2);
      enable = 1'b0;
      step(1);
      chk("drain_running", 32'(running), 1);
      chk("drain_fv",      32'(fetch_valid), 0);
      chk("drain_display", 32'(tft_display), 1);
      step(33);
      enable = 1'b1;
      step(1);
      chk("rerun_fv", 32'(fetch_valid), 1);
      enable = 1'b0;
      step(1);
      step(82);
      chk("dn_x",       32'(x), 16);
      chk("dn_y",       32'(y), 8);
      chk("dn_nf",      32'(new_frame), 1);
      chk("dn_display", 32'(tft_display), 1);
      step(1);
      chk("pd_display", 32'(tft_display), 0);
      chk("pd_vdd",     32'(tft_vdd), 1);
      chk("pd_running", 32'(running), 0);
      chk("pd_x",       32'(x), 0);
      chk("pd_fc",      32'(frame_count), 3);
      chk("pd_hsync",   32'(tft_hsync), 1);
      step(15);
      chk("pd_vdd15", 32'(tft_vdd), 1);
      step(1);
      chk("pd_vdd16", 32'(tft_vdd), 0);

      // restart, then asynchronous reset mid-line
      enable = 1'b1;
      step(17);
      chk("re_display", 32'(tft_display), 1);
      chk("re_fc",      32'(frame_count), 3);
      step(22);
      chk("mid_x",   32'(x), 5);
      chk("mid_y",   32'(y), 1);
      chk("mid_red", 32'(tft_red), 32'h60);
      #2 rstb = 1'b0;
      #1;
      chk("ar_vdd",     32'(tft_vdd), 0);
      chk("ar_display", 32'(tft_display), 0);
      chk("ar_x",       32'(x), 0);
      chk("ar_y",       32'(y), 0);
      chk("ar_red",     32'(tft_red), 0);
      chk("ar_de",      32'(tft_data_ena), 0);
      chk("ar_hsync",   32'(tft_hsync), 1);
      chk("ar_fc",      32'(frame_count), 0);
      chk("ar_running", 32'(running), 0);
      rstb = 1'b1;
      enable = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
